// File: rtl/flow_ctrl_pkg.sv
// Shared flow codes, widths and FSM encodings for the pipeline flow controller.
package flow_ctrl_pkg;

    localparam int FLOW_WIDTH     = 2;
    localparam int REG_ADDR_WIDTH = 5;

    typedef logic [FLOW_WIDTH-1:0] flow_code_t;

    localparam flow_code_t FLOW_WORK    = 2'b00;
    localparam flow_code_t FLOW_STOP    = 2'b01;
    localparam flow_code_t FLOW_REFRESH = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MC_WAIT    = 2'd1,
        ST_TRAP_FLUSH = 2'd2,
        ST_BUS_WAIT   = 2'd3
    } state_t;

    // One flow code per controlled register, PC first.
    typedef struct packed {
        flow_code_t pc;
        flow_code_t if_id;
        flow_code_t id_ex;
        flow_code_t ex_mem;
        flow_code_t mem_wb;
    } flow_t;

    function automatic flow_t mk_flow(input flow_code_t pc, input flow_code_t if_id,
                                      input flow_code_t id_ex, input flow_code_t ex_mem,
                                      input flow_code_t mem_wb);
        flow_t f;
        f.pc     = pc;
        f.if_id  = if_id;
        f.id_ex  = id_ex;
        f.ex_mem = ex_mem;
        f.mem_wb = mem_wb;
        return f;
    endfunction

endpackage

// File: rtl/flow_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX writes a register the ID instruction reads.
module flow_ctrl_hazard_detect #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic                      id_rs1_used_i,
    input  logic                      id_rs2_used_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
    input  logic                      ex_mem_rd_i,
    output logic                      load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    always_comb begin
        rs1_hit    = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
        rs2_hit    = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);
        load_use_o = ex_mem_rd_i && (ex_rd_addr_i != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/flow_ctrl.sv
// Pipeline flow controller: prioritises bus wait, traps, redirects, multi-cycle EX
// ops and load-use hazards into WORK/STOP/REFRESH codes for PC and stage registers.
module flow_ctrl #(
    parameter int FLOW_WIDTH     = flow_ctrl_pkg::FLOW_WIDTH,
    parameter int REG_ADDR_WIDTH = flow_ctrl_pkg::REG_ADDR_WIDTH,
    parameter int MC_MAX_CYC     = 40,
    parameter int TRAP_CYC       = 2,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic                      id_rs1_used_i,
    input  logic                      id_rs2_used_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
    input  logic                      ex_mem_rd_i,
    input  logic                      ex_redirect_i,
    input  logic                      trap_i,
    input  logic                      mc_start_i,
    input  logic                      mc_done_i,
    input  logic                      bus_wait_i,
    output logic [FLOW_WIDTH-1:0]     flow_pc_o,
    output logic [FLOW_WIDTH-1:0]     flow_if_id_o,
    output logic [FLOW_WIDTH-1:0]     flow_id_ex_o,
    output logic [FLOW_WIDTH-1:0]     flow_ex_mem_o,
    output logic [FLOW_WIDTH-1:0]     flow_mem_wb_o,
    output logic                      mc_timeout_o,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

    import flow_ctrl_pkg::*;

    localparam int MC_W = $clog2(MC_MAX_CYC + 1);
    localparam int TC_W = $clog2(TRAP_CYC + 1);
    localparam logic [MC_W-1:0] MC_MAX    = MC_W'(MC_MAX_CYC);
    localparam logic [TC_W-1:0] TRAP_LAST = TC_W'(TRAP_CYC - 1);

    localparam flow_code_t W = FLOW_WORK;
    localparam flow_code_t S = FLOW_STOP;
    localparam flow_code_t R = FLOW_REFRESH;

    state_t              state_q, state_d;
    state_t              ret_q, ret_d;
    logic [MC_W-1:0]     mc_cnt_q, mc_cnt_d;
    logic [TC_W-1:0]     trap_cnt_q, trap_cnt_d;
    logic                pend_trap_q, pend_trap_d;
    logic                pend_redir_q, pend_redir_d;
    logic                pend_done_q, pend_done_d;
    logic                timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    flow_t  flow;
    state_t cur;
    logic   load_use;
    logic   trap_e, redir_e, done_e;
    logic   mc_hit;

    flow_ctrl_hazard_detect #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard (
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .ex_mem_rd_i   (ex_mem_rd_i),
        .load_use_o    (load_use)
    );

    // Next-state and flow codes; leaving BUS_WAIT evaluates the saved state in the same cycle
    // with events that arrived during the wait merged into the live inputs.
    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        mc_cnt_d     = mc_cnt_q;
        trap_cnt_d   = trap_cnt_q;
        pend_trap_d  = 1'b0;
        pend_redir_d = 1'b0;
        pend_done_d  = 1'b0;
        flow         = mk_flow(W, W, W, W, W);

        cur     = (state_q == ST_BUS_WAIT) ? ret_q : state_q;
        trap_e  = trap_i || pend_trap_q;
        redir_e = ex_redirect_i || pend_redir_q;
        done_e  = mc_done_i || pend_done_q;

        if (bus_wait_i) begin
            flow         = mk_flow(S, S, S, S, S);
            state_d      = ST_BUS_WAIT;
            pend_trap_d  = trap_e;
            pend_redir_d = redir_e;
            pend_done_d  = done_e;
            if (state_q != ST_BUS_WAIT)
                ret_d = state_q;
        end else if (trap_e) begin
            flow       = mk_flow(W, R, R, R, W);
            mc_cnt_d   = '0;
            trap_cnt_d = TC_W'(1);
            state_d    = (TRAP_CYC > 1) ? ST_TRAP_FLUSH : ST_RUN;
        end else begin
            state_d = cur;
            case (cur)
                ST_RUN: begin
                    if (redir_e) begin
                        flow = mk_flow(W, R, R, W, W);
                    end else if (mc_start_i) begin
                        if (!mc_done_i) begin
                            flow     = mk_flow(S, S, S, R, W);
                            state_d  = ST_MC_WAIT;
                            mc_cnt_d = MC_W'(1);
                        end
                    end else if (load_use) begin
                        flow = mk_flow(S, S, R, W, W);
                    end
                end
                ST_MC_WAIT: begin
                    if (done_e) begin
                        state_d  = ST_RUN;
                        mc_cnt_d = '0;
                    end else begin
                        flow = mk_flow(S, S, S, R, W);
                        if (mc_cnt_q != MC_MAX)
                            mc_cnt_d = mc_cnt_q + MC_W'(1);
                    end
                end
                ST_TRAP_FLUSH: begin
                    flow       = mk_flow(S, R, R, R, W);
                    trap_cnt_d = trap_cnt_q + TC_W'(1);
                    if (trap_cnt_q >= TRAP_LAST)
                        state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end

        if (rst)
            flow = mk_flow(S, R, R, R, R);
    end

    // Timeout is visible in the cycle the counter reaches the limit, then held.
    always_comb begin
        mc_hit       = (state_q == ST_MC_WAIT) && (mc_cnt_q == MC_MAX);
        timeout_d    = timeout_q || mc_hit;
        mc_timeout_o = timeout_d;
        stall_cnt_d  = stall_cnt_q;
        if (!rst && (flow.if_id != W) && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end

    // Output drive, widened or narrowed to the configured flow width.
    always_comb begin
        flow_pc_o     = FLOW_WIDTH'(flow.pc);
        flow_if_id_o  = FLOW_WIDTH'(flow.if_id);
        flow_id_ex_o  = FLOW_WIDTH'(flow.id_ex);
        flow_ex_mem_o = FLOW_WIDTH'(flow.ex_mem);
        flow_mem_wb_o = FLOW_WIDTH'(flow.mem_wb);
        stall_cnt_o   = stall_cnt_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            ret_q        <= ST_RUN;
            mc_cnt_q     <= '0;
            trap_cnt_q   <= '0;
            pend_trap_q  <= 1'b0;
            pend_redir_q <= 1'b0;
            pend_done_q  <= 1'b0;
            timeout_q    <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            mc_cnt_q     <= mc_cnt_d;
            trap_cnt_q   <= trap_cnt_d;
            pend_trap_q  <= pend_trap_d;
            pend_redir_q <= pend_redir_d;
            pend_done_q  <= pend_done_d;
            timeout_q    <= timeout_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_flow_ctrl.sv
// Directed bench for flow_ctrl: a default-parameter instance plus a short-timeout
// instance sharing the same stimulus.
module tb_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic       id_rs1_used, id_rs2_used, ex_mem_rd, ex_redirect, trap, mc_start, mc_done, bus_wait;

    logic [1:0]  a_pc, a_ifid, a_idex, a_exmem, a_memwb;
    logic        a_tmo;
    logic [31:0] a_stall;
    logic [1:0]  b_pc, b_ifid, b_idex, b_exmem, b_memwb;
    logic        b_tmo;
    logic [31:0] b_stall;

    int tests = 0;
    int fails = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    flow_ctrl u_dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .ex_rd_addr_i(ex_rd_addr), .ex_mem_rd_i(ex_mem_rd),
        .ex_redirect_i(ex_redirect), .trap_i(trap),
        .mc_start_i(mc_start), .mc_done_i(mc_done), .bus_wait_i(bus_wait),
        .flow_pc_o(a_pc), .flow_if_id_o(a_ifid), .flow_id_ex_o(a_idex),
        .flow_ex_mem_o(a_exmem), .flow_mem_wb_o(a_memwb),
        .mc_timeout_o(a_tmo), .stall_cnt_o(a_stall)
    );

    flow_ctrl #(.MC_MAX_CYC(4)) u_tmo (
        .clk(clk), .rst(rst),
        .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .ex_rd_addr_i(ex_rd_addr), .ex_mem_rd_i(ex_mem_rd),
        .ex_redirect_i(ex_redirect), .trap_i(trap),
        .mc_start_i(mc_start), .mc_done_i(mc_done), .bus_wait_i(bus_wait),
        .flow_pc_o(b_pc), .flow_if_id_o(b_ifid), .flow_id_ex_o(b_idex),
        .flow_ex_mem_o(b_exmem), .flow_mem_wb_o(b_memwb),
        .mc_timeout_o(b_tmo), .stall_cnt_o(b_stall)
    );

    // "WSRWW" style tuple -> packed 10-bit code (W=00, S=01, R=10).
    function automatic logic [9:0] fl(input string s);
        logic [9:0] v = '0;
        for (int i = 0; i < 5; i++) begin
            v = v << 2;
            if (s[i] == "S") v[1:0] = 2'b01;
            else if (s[i] == "R") v[1:0] = 2'b10;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check flow tuple for this cycle, account expected stall, advance one clock.
    task automatic step(input string tag, input string t);
        logic [9:0] e;
        e = fl(t);
        #1;
        chk(tag, {22'd0, a_pc, a_ifid, a_idex, a_exmem, a_memwb}, {22'd0, e});
        if (!rst && e[7:6] != 2'b00) exp_stall++;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
        id_rs1_used = 0; id_rs2_used = 0; ex_mem_rd = 0; ex_redirect = 0;
        trap = 0; mc_start = 0; mc_done = 0; bus_wait = 0;
        tick();

        // Reset state
        step("rst_flow", "SRRRR");
        chk("rst_stall", a_stall, 0);
        chk("rst_tmo", {31'd0, a_tmo}, 0);
        rst = 1'b0;
        step("idle", "WWWWW");

        // Load-use on rs2
        ex_mem_rd = 1; ex_rd_addr = 5; id_rs2_addr = 5; id_rs2_used = 1;
        step("lu_stall", "SSRWW");
        ex_mem_rd = 0;
        step("lu_after", "WWWWW");
        // rs1 match but unused -> no hazard
        ex_mem_rd = 1; id_rs2_used = 0; id_rs1_addr = 5; id_rs1_used = 0;
        step("lu_unused", "WWWWW");
        // Load to x0
        ex_rd_addr = 0; id_rs1_addr = 0; id_rs1_used = 1;
        step("x0_load", "WWWWW");
        chk("x0_stall", a_stall, exp_stall);
        ex_mem_rd = 0; id_rs1_used = 0;

        // Divide: 33 stall cycles; short-timeout instance trips in its 4th wait cycle
        mc_start = 1;
        step("div_start", "SSSRW");
        mc_start = 0;
        for (int i = 1; i <= 32; i++) begin
            #1;
            chk($sformatf("tmo_c%0d", i), {31'd0, b_tmo}, (i >= 4) ? 1 : 0);
            step($sformatf("div_w%0d", i), "SSSRW");
        end
        mc_done = 1;
        step("div_done", "WWWWW");
        mc_done = 0;
        step("div_after", "WWWWW");
        chk("tmo_sticky", {31'd0, b_tmo}, 1);
        chk("no_tmo_40", {31'd0, a_tmo}, 0);
        chk("div_stall", a_stall, exp_stall);

        // Trap during MC_WAIT, redirect ignored in the flush
        mc_start = 1;
        step("mc2_start", "SSSRW");
        mc_start = 0;
        step("mc2_wait", "SSSRW");
        trap = 1;
        step("trap", "WRRRW");
        trap = 0; ex_redirect = 1;
        chk("trap_mccnt", {26'd0, u_dut.mc_cnt_q}, 0);
        step("trap_flush", "SRRRW");
        ex_redirect = 0;
        step("trap_done", "WWWWW");

        // Bus wait with redirect arriving mid-wait
        bus_wait = 1;
        step("bw1", "SSSSS");
        ex_redirect = 1;
        step("bw2", "SSSSS");
        ex_redirect = 0;
        step("bw3", "SSSSS");
        bus_wait = 0;
        step("bw_redir", "WRRWW");
        step("bw_after", "WWWWW");

        // Redirect beats load-use
        ex_redirect = 1; ex_mem_rd = 1; ex_rd_addr = 7; id_rs1_addr = 7; id_rs1_used = 1;
        step("redir_lu", "WRRWW");
        ex_redirect = 0; ex_mem_rd = 0; id_rs1_used = 0;
        // Trap beats redirect
        trap = 1; ex_redirect = 1;
        step("trap_redir", "WRRRW");
        trap = 0; ex_redirect = 0;
        step("trap_redir_fl", "SRRRW");
        step("trap_redir_run", "WWWWW");
        // Same-cycle multi-cycle completion
        mc_start = 1; mc_done = 1;
        step("mc_fast", "WWWWW");
        mc_start = 0; mc_done = 0;
        step("mc_fast_after", "WWWWW");
        chk("final_stall", a_stall, exp_stall);
        chk("tmo_still", {31'd0, b_tmo}, 1);

        // Reset clears sticky timeout and counter
        rst = 1;
        tick();
        #1;
        chk("rst2_tmo", {31'd0, b_tmo}, 0);
        chk("rst2_stall", a_stall, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
